// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arbiter
// Description : Round-robin arbiter sharing one spi_master frame engine among
//               NREQ requesters. It grants one owner, launches a frame,
//               supervises it with a timeout and returns the received word
//               with a one-cycle done (or err) pulse to that owner.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic [DW-1:0]      rd_data,
    output logic               busy,
    output logic               m_start,
    output logic [DW-1:0]      m_tx_data,
    output logic               m_abort,
    input  logic               m_busy,
    input  logic               m_done,
    input  logic [DW-1:0]      m_rx_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW:0]     w_sum;
    logic [PW:0]     w_ptr_sum;
    logic            w_found;
    logic            w_grant;
    logic            w_timeout;
    logic [NREQ-1:0] w_owner_oh;

    // Owner index expanded to a one-hot vector for gnt/done/err
    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign busy       = (r_state != S_IDLE);
    // Grant is held through START/WAIT/RESP and drops as soon as IDLE is entered
    assign gnt        = busy ? w_owner_oh : '0;

    // Round-robin search starting at r_ptr, wrapping modulo NREQ
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_sum     = '0;
        w_ptr_sum = '0;
        w_ptr_nxt = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            if (!w_found && req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
        w_ptr_sum = {1'b0, w_win} + (PW+1)'(1);
        w_ptr_nxt = (w_ptr_sum == (PW+1)'(NREQ)) ? '0 : w_ptr_sum[PW-1:0];
    end

    // Transaction FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pulse outputs; m_done beats a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = (r_cnt == CW'(TIMEOUT));
        m_start     = 1'b0;
        m_abort     = 1'b0;
        done        = '0;
        err         = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !m_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                m_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    m_abort     = 1'b1;
                    err         = w_owner_oh;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                done        = w_owner_oh;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Owner/pointer capture at grant, frame timeout counter and rx capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            rd_data   <= '0;
            m_tx_data <= '0;
        end else begin
            if (w_grant) begin
                // Pointer moves past the winner at grant; the same rotation
                // therefore applies whether the frame completes or times out
                r_owner   <= w_win;
                r_ptr     <= w_ptr_nxt;
                m_tx_data <= req_data[w_win*DW +: DW];
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_WAIT && m_done) begin
                rd_data <= m_rx_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arbiter
// Description : Self-checking bench for spi_master_arbiter. Two instances share
//               stimulus: dut_a (long timeout) for normal traffic, dut_b
//               (TIMEOUT=8) for timeout behaviour. A stub models spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 24;

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [DW-1:0]   data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               m_busy;
    logic               m_done;
    logic [DW-1:0]      m_rx_data;

    logic [NREQ-1:0] gnt_a, done_a, err_a, gnt_b, done_b, err_b;
    logic [DW-1:0]   rd_a, mtx_a, rd_b, mtx_b;
    logic            busy_a, mstart_a, mabort_a, busy_b, mstart_b, mabort_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Stub controls
    logic          stub_en    = 1'b0;
    logic          stub_tgt   = 1'b0;
    logic          stub_fixed = 1'b0;
    int            stub_lat   = 1;
    logic [DW-1:0] stub_data  = '0;
    logic [DW-1:0] stub_tx;

    always #5 clk = ~clk;

    spi_master_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(1023)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt_a), .done(done_a), .err(err_a), .rd_data(rd_a), .busy(busy_a),
        .m_start(mstart_a), .m_tx_data(mtx_a), .m_abort(mabort_a),
        .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data)
    );

    spi_master_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt_b), .done(done_b), .err(err_b), .rd_data(rd_b), .busy(busy_b),
        .m_start(mstart_b), .m_tx_data(mtx_b), .m_abort(mabort_b),
        .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data)
    );

    // spi_master stub: m_done stub_lat cycles after the selected m_start;
    // returns stub_data or the inverted tx word
    initial begin
        m_done    = 1'b0;
        m_rx_data = '0;
        forever begin
            @(negedge clk);
            if (stub_en && (stub_tgt ? mstart_b : mstart_a)) begin
                stub_tx = stub_tgt ? mtx_b : mtx_a;
                repeat (stub_lat) @(posedge clk);
                #1;
                m_done    = 1'b1;
                m_rx_data = stub_fixed ? stub_data : ~stub_tx;
                @(posedge clk);
                #1;
                m_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1);
    end

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        m_busy   = 1'b0;
        stub_en  = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({gnt_a, done_a, err_a, rd_a, busy_a, mstart_a, mtx_a, mabort_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: gnt=%b done=%b err=%b rd=%h busy=%b mstart=%b mtx=%h mabort=%b (want all 0)",
                     gnt_a, done_a, err_a, rd_a, busy_a, mstart_a, mtx_a, mabort_a);
        end
        n_tests++;
        if ({gnt_b, done_b, err_b, rd_b, busy_b, mstart_b, mtx_b, mabort_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: gnt=%b done=%b err=%b rd=%h busy=%b mstart=%b mtx=%h mabort=%b (want all 0)",
                     gnt_b, done_b, err_b, rd_b, busy_b, mstart_b, mtx_b, mabort_b);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   s_cyc   = -1;
        int   n_start = 0;
        bit   got     = 0;
        do_reset();
        stub_en = 1'b1; stub_tgt = 1'b0; stub_fixed = 1'b1;
        stub_data = 24'hFEDCBA; stub_lat = 10;
        @(posedge clk);
        #1;
        req_data = '0;
        req_data[0 +: DW] = 24'hABCDEF;
        req = 4'b0001;
        e.oh = 4'b0001; e.data = 24'hFEDCBA;
        exp_q.push_back(e);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mstart_a) begin
                n_start++;
                s_cyc = c;
                n_tests++;
                if (c != 1 || mtx_a !== 24'hABCDEF || gnt_a !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL single_start: cycle=%0d mtx=%h gnt=%b (want cycle=1 mtx=abcdef gnt=0001)",
                             c, mtx_a, gnt_a);
                end
            end
            if (|done_a) begin
                got = 1;
                e = exp_q.pop_front();
                n_tests++;
                if (done_a !== e.oh || rd_a !== e.data || c != s_cyc + 11) begin
                    n_fail++;
                    $display("FAIL single_done: done=%b rd=%h cycle=%0d (want done=%b rd=%h cycle=%0d)",
                             done_a, rd_a, c, e.oh, e.data, s_cyc + 11);
                end
                @(posedge clk);
                #1;
                req = '0;
                @(negedge clk);
                n_tests++;
                if (gnt_a !== '0 || busy_a !== 1'b0 || rd_a !== 24'hFEDCBA) begin
                    n_fail++;
                    $display("FAIL single_release: gnt=%b busy=%b rd=%h (want gnt=0000 busy=0 rd=fedcba)",
                             gnt_a, busy_a, rd_a);
                end
            end
        end
        n_tests++;
        if (!got || n_start != 1) begin
            n_fail++;
            $display("FAIL single_count: done_seen=%0d starts=%0d (want 1 and 1)", got, n_start);
        end
        stub_en = 1'b0;
    endtask

    task automatic test_round_robin();
        int   gnt_q[$];
        exp_t e;
        int   g;
        int   n_start = 0;
        int   n_done  = 0;
        int   prev_s  = -1;
        do_reset();
        stub_en = 1'b1; stub_tgt = 1'b0; stub_fixed = 1'b0; stub_lat = 1;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = DW'(24'hC00007 + i * 24'h010101);
        end
        gnt_q = '{0, 1, 2, 3, 0, 1, 2, 0};
        @(posedge clk);
        #1;
        req = 4'b1111;
        for (int c = 0; c < 200 && n_done < 8; c++) begin
            @(negedge clk);
            if (mstart_a) begin
                n_start++;
                n_tests++;
                if (gnt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_grant: unexpected start gnt=%b (want no start)", gnt_a);
                end else begin
                    g = gnt_q.pop_front();
                    if (gnt_a !== 4'(1 << g) || mtx_a !== req_data[g*DW +: DW]) begin
                        n_fail++;
                        $display("FAIL rr_grant: #%0d gnt=%b mtx=%h (want gnt=%b mtx=%h)",
                                 n_start, gnt_a, mtx_a, 4'(1 << g), req_data[g*DW +: DW]);
                    end
                    e.oh = 4'(1 << g); e.data = ~req_data[g*DW +: DW];
                    exp_q.push_back(e);
                end
                if (prev_s >= 0) begin
                    n_tests++;
                    if (c - prev_s != 4) begin
                        n_fail++;
                        $display("FAIL rr_spacing: start-to-start=%0d (want 4)", c - prev_s);
                    end
                end
                prev_s = c;
                if (n_start == 7) begin
                    @(posedge clk);
                    #1;
                    req[3] = 1'b0;
                end
            end
            if (|done_a) begin
                n_done++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_done: unexpected done=%b (want none)", done_a);
                end else begin
                    e = exp_q.pop_front();
                    if (done_a !== e.oh || rd_a !== e.data || err_a !== '0) begin
                        n_fail++;
                        $display("FAIL rr_done: done=%b rd=%h err=%b (want done=%b rd=%h err=0000)",
                                 done_a, rd_a, err_a, e.oh, e.data);
                    end
                end
                if (n_done == 8) begin
                    @(posedge clk);
                    #1;
                    req = '0;
                end
            end
        end
        n_tests++;
        if (n_done != 8 || gnt_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_count: dones=%0d grants_left=%0d (want 8 and 0)", n_done, gnt_q.size());
        end
        repeat (4) @(negedge clk);
        stub_en = 1'b0;
    endtask

    task automatic test_timeout();
        int own_q[$];
        int o;
        int s_cyc  = -100;
        int n_ab   = 0;
        bit chk    = 0;
        bit spur   = 0;
        do_reset();
        own_q = '{0, 1};
        @(posedge clk);
        #1;
        req = 4'b0011;
        for (int c = 0; c < 100 && !(n_ab == 2 && !chk); c++) begin
            @(negedge clk);
            if (chk) begin
                chk = 0;
                n_tests++;
                if (mabort_b !== 1'b0 || err_b !== '0 || gnt_b !== '0 || busy_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL to_after: mabort=%b err=%b gnt=%b busy=%b (want 0 0000 0000 0)",
                             mabort_b, err_b, gnt_b, busy_b);
                end
            end
            if (mstart_b) begin
                s_cyc = c;
                n_tests++;
                if (own_q.size() == 0 || gnt_b !== 4'(1 << own_q[0])) begin
                    n_fail++;
                    $display("FAIL to_grant: gnt=%b (want %b)", gnt_b,
                             own_q.size() == 0 ? 4'b0000 : 4'(1 << own_q[0]));
                end
            end
            if (|done_b) spur = 1;
            if (mabort_b || |err_b) begin
                n_ab++;
                n_tests++;
                o = (own_q.size() != 0) ? own_q.pop_front() : 0;
                if (mabort_b !== 1'b1 || err_b !== 4'(1 << o) || c != s_cyc + 9) begin
                    n_fail++;
                    $display("FAIL to_abort: mabort=%b err=%b cycles_after_start=%0d (want 1 %b 9)",
                             mabort_b, err_b, c - s_cyc, 4'(1 << o));
                end
                chk = 1;
                if (n_ab == 2) begin
                    @(posedge clk);
                    #1;
                    req = '0;
                end
            end
        end
        n_tests++;
        if (n_ab != 2 || spur) begin
            n_fail++;
            $display("FAIL to_count: aborts=%0d spurious_done=%0d (want 2 and 0)", n_ab, spur);
        end
    endtask

    task automatic test_done_timeout_collide();
        exp_t e;
        int   s_cyc = -100;
        bit   got   = 0;
        bit   bad   = 0;
        do_reset();
        stub_en = 1'b1; stub_tgt = 1'b1; stub_fixed = 1'b1;
        stub_data = 24'h5A1234; stub_lat = 9;
        @(posedge clk);
        #1;
        req = 4'b0001;
        e.oh = 4'b0001; e.data = 24'h5A1234;
        exp_q.push_back(e);
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (mstart_b) s_cyc = c;
            if (mabort_b || |err_b) bad = 1;
            if (|done_b) begin
                got = 1;
                e = exp_q.pop_front();
                n_tests++;
                if (done_b !== e.oh || rd_b !== e.data || c != s_cyc + 10) begin
                    n_fail++;
                    $display("FAIL collide_done: done=%b rd=%h cycles_after_start=%0d (want %b %h 10)",
                             done_b, rd_b, c - s_cyc, e.oh, e.data);
                end
                @(posedge clk);
                #1;
                req = '0;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (mabort_b || |err_b) bad = 1;
        end
        n_tests++;
        if (!got || bad) begin
            n_fail++;
            $display("FAIL collide_noabort: done_seen=%0d abort_or_err=%0d (want 1 and 0)", got, bad);
        end
        stub_en = 1'b0;
    endtask

    task automatic test_busy_reset();
        bit bad = 0;
        do_reset();
        m_busy = 1'b1;
        req_data[1*DW +: DW] = 24'h13579B;
        @(posedge clk);
        #1;
        req = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            if (gnt_a !== '0 || busy_a !== 1'b0) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL busy_hold: grant seen while m_busy=1 (want none)");
        end
        @(posedge clk);
        #1;
        m_busy = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt_a !== '0 || mstart_a !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: gnt=%b mstart=%b (want 0000 0)", gnt_a, mstart_a);
        end
        @(negedge clk);
        n_tests++;
        if (gnt_a !== 4'b0010 || mstart_a !== 1'b1 || mtx_a !== 24'h13579B) begin
            n_fail++;
            $display("FAIL busy_grant: gnt=%b mstart=%b mtx=%h (want 0010 1 13579b)", gnt_a, mstart_a, mtx_a);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({gnt_a, done_a, err_a, busy_a, mabort_a, mtx_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_wait_a: gnt=%b done=%b err=%b busy=%b mabort=%b mtx=%h (want all 0)",
                     gnt_a, done_a, err_a, busy_a, mabort_a, mtx_a);
        end
        n_tests++;
        if ({gnt_b, done_b, err_b, busy_b, mabort_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_wait_b: gnt=%b done=%b err=%b busy=%b mabort=%b (want all 0)",
                     gnt_b, done_b, err_b, busy_b, mabort_b);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (|done_a || |err_a || mabort_a || |done_b || |err_b || mabort_b || busy_a || busy_b) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_quiet: activity after mid-frame reset (want none)");
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        m_busy   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_timeout_collide();
        test_busy_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter that shares one `spi_master` frame engine between `NREQ` requesters. Each requester presents a 24-bit transmit word. The arbiter:

- grants one requester at a time;
- launches the frame;
- waits for completion;
- returns the received 24-bit word to the owner with a one-cycle done pulse.

It sits between the local RAM/control clients and `spi_master`. It also supervises each frame with a timeout.

## Interface

- `NREQ`, 4, number of requesters (2..8)
- `DW`, 24, SPI frame / word width
- `TIMEOUT`, 1023, max cycles from `m_start` to `m_done` before abort (≥ 4)

- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  request per requester, level
- `req_data`  in  NREQ*DW  tx word; requester i at `[i*DW +: DW]`
- `gnt`  out  NREQ  one-hot grant, held for whole transaction
- `done`  out  NREQ  one-cycle completion pulse to owner
- `err`  out  NREQ  one-cycle timeout pulse to owner
- `rd_data`  out  DW  received word, valid in `done` cycle, held until next `done`
- `busy`  out  1  high in any state except IDLE
- `m_start`  out  1  one-cycle frame start to `spi_master`
- `m_tx_data`  out  DW  frame tx word, stable from `m_start` until return to IDLE
- `m_abort`  out  1  one-cycle abort to `spi_master` on timeout
- `m_busy`  in  1  master busy (frame in flight or recovering)
- `m_done`  in  1  one-cycle frame complete
- `m_rx_data`  in  DW  received frame, valid with `m_done`

## Operation

- **States:** IDLE, START, WAIT, RESP.
- **IDLE**
  - If any `req` is high and `m_busy`=0: pick a winner by round-robin and go to START.
  - In the same edge: latch `gnt`, capture `req_data` slice into `m_tx_data`.
- **Round-robin**
  - Pointer `ptr` (log2 NREQ bits) holds the highest priority index.
  - Search order: `ptr`, `ptr+1`, … modulo NREQ.
  - After a grant to i, `ptr` ← (i+1) mod NREQ; this applies on both completion and timeout.
- **START:** assert `m_start` for exactly one cycle, clear timeout counter, go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `m_done`: capture `m_rx_data` into `rd_data`, go to RESP.
  - When counter reaches `TIMEOUT` with no `m_done`:
    - pulse `m_abort` and `err[owner]`;
    - clear `gnt`;
    - go to IDLE.
  - If `m_done` and timeout occur in the same cycle, `m_done` wins: no abort, no err.
- **RESP:** `done[owner]`=1 for one cycle, `gnt` still held, go to IDLE. `gnt` drops on entry to IDLE.
- **Requester behaviour**
  - The owner dropping `req` after the grant is ignored; the transaction completes and `done` still pulses.
  - A requester holding `req` after `done` re-enters arbitration at normal round-robin priority. There is no back-to-back monopoly when others are requesting.
- **Other master inputs:** `m_done` outside WAIT is ignored. `m_busy` is only checked in IDLE.
- **Reset** (any state, including mid-frame):
  - next state IDLE, `ptr`=0, counter=0;
  - all outputs 0, including `rd_data` and `m_tx_data`;
  - no `m_abort` is generated.

## Timing

- **Request to start:** `req` seen in IDLE at edge N → `gnt` and START from N+1 → `m_start` high during cycle N+1 only.
- **Completion:** `m_done` at cycle M → `done` and `rd_data` valid at cycle M+1 → `gnt` low and IDLE at M+2. The next grant can occur at edge M+2, with `m_start` in M+3.
- **Timeout:** `m_start` at cycle S → abort at cycle S+1+TIMEOUT if `m_done` has not been seen. `m_abort` and `err` are coincident and one cycle wide.
- **Arbitration overhead:** minimum 3 cycles per transaction beyond the frame itself.
- **Output relationships:**
  - `gnt` is one-hot or zero at all times.
  - `done` and `err` are never both high.
  - `busy` = (state ≠ IDLE).

## Test plan

- **Reset:** after reset, all outputs are 0.
- **Single request:** `req`=0001, `req_data[0]`=24'hABCDEF; stub returns `m_rx_data`=24'hFEDCBA 10 cycles after `m_start`.
  - `m_start` fires once with `m_tx_data`=ABCDEF.
  - `done`=0001 with `rd_data`=FEDCBA one cycle after `m_done`.
- **Round-robin:** hold `req`=1111 with an immediate-done stub. Grant order is 0,1,2,3,0. After a grant to 2, dropping `req[3]` gives next grant 0.
- **Timeout:** `TIMEOUT`=8; stub never asserts `m_done`.
  - `m_abort` and `err`=0001 occur exactly 9 cycles after `m_start`.
  - Next grant goes to requester 1 if requesting.
- **Simultaneous done and timeout:** stub asserts `m_done` on the exact timeout cycle. `done` pulses, with no `m_abort` and no `err`.
- **Busy and reset:**
  - With `m_busy`=1 in IDLE and `req`=0010: no grant until `m_busy` falls; grant comes the next edge.
  - Asserting `rst` during WAIT: IDLE next cycle, `gnt`=0, no `done`/`err`/`m_abort`.
